// File: rtl/sprite_motion_pkg.sv
// ============================================================================
// Module      : sprite_motion_pkg
// Description : Shared types and helpers for the sprite motion engine:
//               sweep FSM state encoding, per-sprite state record and the
//               playfield-limit computation.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_motion_pkg;

  // Storage widths of the per-sprite record. Instances use POS_W/SPEED_W
  // bits of these fields; the record is sized for the largest legal build.
  localparam int MAX_POS_W   = 16;
  localparam int MAX_SPEED_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic [MAX_POS_W-1:0]   x;
    logic [MAX_POS_W-1:0]   y;
    logic [MAX_SPEED_W-1:0] sx;
    logic [MAX_SPEED_W-1:0] sy;
    logic                   xdir;
    logic                   ydir;
  } sprite_t;

  // Largest legal top-left coordinate along one axis.
  function automatic int calc_max(input int extent, input int box);
    return extent - box;
  endfunction

  // Power-up record: at the origin, moving towards increasing coordinates,
  // one pixel per frame on both axes.
  function automatic sprite_t reset_sprite();
    sprite_t s;
    s.x    = '0;
    s.y    = '0;
    s.sx   = MAX_SPEED_W'(1);
    s.sy   = MAX_SPEED_W'(1);
    s.xdir = 1'b0;
    s.ydir = 1'b0;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_axis_step.sv
// ============================================================================
// Module      : sprite_axis_step
// Description : Combinational single-axis motion step with edge reflection.
// Ports       : pos, speed, dir, max_pos  -> current axis state and limit
//               pos_next, dir_next, hit   -> updated state, edge-hit flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_axis_step #(
  parameter int POS_W   = 8,
  parameter int SPEED_W = 3
) (
  input  logic [POS_W-1:0]   pos,
  input  logic [SPEED_W-1:0] speed,
  input  logic               dir,
  input  logic [POS_W-1:0]   max_pos,
  output logic [POS_W-1:0]   pos_next,
  output logic               dir_next,
  output logic               hit
);

  // One extra bit so pos+speed can never wrap before the limit compare.
  logic [POS_W:0] pos_ext;
  logic [POS_W:0] spd_ext;
  logic [POS_W:0] max_ext;
  logic [POS_W:0] sum;

  assign pos_ext = {1'b0, pos};
  assign spd_ext = (POS_W+1)'(speed);
  assign max_ext = {1'b0, max_pos};
  assign sum     = pos_ext + spd_ext;

  always_comb begin
    pos_next = pos;
    dir_next = dir;
    hit      = 1'b0;
    if (speed != '0) begin
      if (!dir) begin
        if (sum >= max_ext) begin
          pos_next = max_pos;
          dir_next = 1'b1;
          hit      = 1'b1;
        end else begin
          pos_next = sum[POS_W-1:0];
        end
      end else begin
        if (pos_ext <= spd_ext) begin
          pos_next = '0;
          dir_next = 1'b0;
          hit      = 1'b1;
        end else begin
          pos_next = pos - POS_W'(speed);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sprite_motion_engine.sv
// ============================================================================
// Module      : sprite_motion_engine
// Description : Per-frame motion engine for NUM_SPRITES bouncing sprites.
//               A sweep FSM advances one sprite per cycle after each
//               accepted frame tick, sharing one X and one Y step unit.
// Ports       : clk, reset               - clock, synchronous active-high reset
//               next_frame, enable       - frame tick and its qualifier
//               cfg_*                    - per-sprite configuration write
//               sprite_x/_y, *_dir       - flattened positions / directions
//               bounce, busy, frame_done, frame_overrun - status
//               collision                - only with SPRITE_MOTION_COLLISION_EN
// Options     : `define SPRITE_MOTION_COLLISION_EN adds box-overlap detection
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_motion_engine
  import sprite_motion_pkg::*;
#(
  parameter int NUM_SPRITES   = 2,
  parameter int POS_W         = 8,
  parameter int SPEED_W       = 3,
  parameter int SPRITE_WIDTH  = 16,
  parameter int SPRITE_HEIGHT = 16,
  parameter int WIDTH_SMALL   = 160,
  parameter int HEIGHT_SMALL  = 120
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     next_frame,
  input  logic                     enable,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [2:0]               cfg_idx,
  input  logic [POS_W-1:0]         cfg_x,
  input  logic [POS_W-1:0]         cfg_y,
  input  logic [SPEED_W-1:0]       cfg_sx,
  input  logic [SPEED_W-1:0]       cfg_sy,
  input  logic                     cfg_xdir,
  input  logic                     cfg_ydir,
  output logic [NUM_SPRITES*POS_W-1:0] sprite_x,
  output logic [NUM_SPRITES*POS_W-1:0] sprite_y,
  output logic [NUM_SPRITES-1:0]   sprite_x_dir,
  output logic [NUM_SPRITES-1:0]   sprite_y_dir,
  output logic [NUM_SPRITES-1:0]   bounce,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     frame_overrun
`ifdef SPRITE_MOTION_COLLISION_EN
  ,
  output logic [NUM_SPRITES-1:0]   collision
`endif
);

  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [POS_W-1:0] XMAX = POS_W'(calc_max(WIDTH_SMALL, SPRITE_WIDTH));
  localparam logic [POS_W-1:0] YMAX = POS_W'(calc_max(HEIGHT_SMALL, SPRITE_HEIGHT));

  state_t           state;
  logic [IDX_W-1:0] idx;
  sprite_t          spr [NUM_SPRITES];

  sprite_t          cur;
  sprite_t          cfg_entry;
  logic [POS_W-1:0] x_next;
  logic [POS_W-1:0] y_next;
  logic             xdir_next;
  logic             ydir_next;
  logic             x_hit;
  logic             y_hit;

  assign cur       = spr[idx];
  assign busy      = (state != ST_IDLE);
  assign cfg_ready = (state == ST_IDLE);

  // Clamped configuration record, written as a whole on a handshake.
  always_comb begin
    cfg_entry      = reset_sprite();
    cfg_entry.x    = MAX_POS_W'((cfg_x > XMAX) ? XMAX : cfg_x);
    cfg_entry.y    = MAX_POS_W'((cfg_y > YMAX) ? YMAX : cfg_y);
    cfg_entry.sx   = MAX_SPEED_W'(cfg_sx);
    cfg_entry.sy   = MAX_SPEED_W'(cfg_sy);
    cfg_entry.xdir = cfg_xdir;
    cfg_entry.ydir = cfg_ydir;
  end

  sprite_axis_step #(.POS_W(POS_W), .SPEED_W(SPEED_W)) u_step_x (
    .pos      (POS_W'(cur.x)),
    .speed    (SPEED_W'(cur.sx)),
    .dir      (cur.xdir),
    .max_pos  (XMAX),
    .pos_next (x_next),
    .dir_next (xdir_next),
    .hit      (x_hit)
  );

  sprite_axis_step #(.POS_W(POS_W), .SPEED_W(SPEED_W)) u_step_y (
    .pos      (POS_W'(cur.y)),
    .speed    (SPEED_W'(cur.sy)),
    .dir      (cur.ydir),
    .max_pos  (YMAX),
    .pos_next (y_next),
    .dir_next (ydir_next),
    .hit      (y_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      idx           <= '0;
      bounce        <= '0;
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        spr[i] <= reset_sprite();
      end
    end else begin
      bounce        <= '0;
      frame_done    <= 1'b0;
      // A tick during a sweep is dropped, never queued.
      frame_overrun <= next_frame && enable && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          // Out-of-range indices complete the handshake without a write.
          if (cfg_valid && (int'(cfg_idx) < NUM_SPRITES)) begin
            spr[cfg_idx[IDX_W-1:0]] <= cfg_entry;
          end
          if (next_frame && enable) begin
            state <= ST_UPDATE;
            idx   <= '0;
          end
        end
        ST_UPDATE: begin
          spr[idx].x    <= MAX_POS_W'(x_next);
          spr[idx].y    <= MAX_POS_W'(y_next);
          spr[idx].xdir <= xdir_next;
          spr[idx].ydir <= ydir_next;
          bounce[idx]   <= x_hit | y_hit;
          if (idx == IDX_W'(NUM_SPRITES - 1)) begin
            state      <= ST_DONE;
            frame_done <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_flatten
    assign sprite_x[i*POS_W +: POS_W] = POS_W'(spr[i].x);
    assign sprite_y[i*POS_W +: POS_W] = POS_W'(spr[i].y);
    assign sprite_x_dir[i]            = spr[i].xdir;
    assign sprite_y_dir[i]            = spr[i].ydir;
  end

`ifdef SPRITE_MOTION_COLLISION_EN
  logic [NUM_SPRITES-1:0] overlap;

  // Half-open boxes overlap when each starts before the other one ends.
  always_comb begin
    overlap = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      for (int j = 0; j < NUM_SPRITES; j++) begin
        if ((i != j) &&
            (int'(spr[i].x) < int'(spr[j].x) + SPRITE_WIDTH) &&
            (int'(spr[j].x) < int'(spr[i].x) + SPRITE_WIDTH) &&
            (int'(spr[i].y) < int'(spr[j].y) + SPRITE_HEIGHT) &&
            (int'(spr[j].y) < int'(spr[i].y) + SPRITE_HEIGHT)) begin
          overlap[i] = 1'b1;
        end
      end
    end
  end

  // Sampled in DONE, when every sprite holds its final position.
  always_ff @(posedge clk) begin
    if (reset) begin
      collision <= '0;
    end else if (state == ST_DONE) begin
      collision <= overlap;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sprite_motion_engine.sv
// ============================================================================
// Module      : tb_sprite_motion_engine
// Description : Self-checking bench for sprite_motion_engine. A frame-level
//               reference model predicts every output each cycle; directed
//               scenarios add hand-computed literal expectations.
// Options     : honours SPRITE_MOTION_COLLISION_EN
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sprite_motion_engine;

  localparam int N    = 2;
  localparam int PW   = 8;
  localparam int SW   = 3;
  localparam int XMAX = 144;
  localparam int YMAX = 104;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          next_frame = 1'b0;
  logic          enable = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [2:0]    cfg_idx = '0;
  logic [PW-1:0] cfg_x = '0;
  logic [PW-1:0] cfg_y = '0;
  logic [SW-1:0] cfg_sx = '0;
  logic [SW-1:0] cfg_sy = '0;
  logic          cfg_xdir = 1'b0;
  logic          cfg_ydir = 1'b0;
  logic [N*PW-1:0] sprite_x;
  logic [N*PW-1:0] sprite_y;
  logic [N-1:0]  sprite_x_dir;
  logic [N-1:0]  sprite_y_dir;
  logic [N-1:0]  bounce;
  logic          busy;
  logic          frame_done;
  logic          frame_overrun;
`ifdef SPRITE_MOTION_COLLISION_EN
  logic [N-1:0]  collision;
`endif

  sprite_motion_engine #(.NUM_SPRITES(N), .POS_W(PW), .SPEED_W(SW)) dut (
    .clk           (clk),
    .reset         (reset),
    .next_frame    (next_frame),
    .enable        (enable),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_idx       (cfg_idx),
    .cfg_x         (cfg_x),
    .cfg_y         (cfg_y),
    .cfg_sx        (cfg_sx),
    .cfg_sy        (cfg_sy),
    .cfg_xdir      (cfg_xdir),
    .cfg_ydir      (cfg_ydir),
    .sprite_x      (sprite_x),
    .sprite_y      (sprite_y),
    .sprite_x_dir  (sprite_x_dir),
    .sprite_y_dir  (sprite_y_dir),
    .bounce        (bounce),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_overrun (frame_overrun)
`ifdef SPRITE_MOTION_COLLISION_EN
    ,
    .collision     (collision)
`endif
  );

  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input integer act, input integer exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame granularity) ----------------
  int mx [N], my [N], msx [N], msy [N], mxd [N], myd [N];
  int fx [N], fy [N], fxd [N], fyd [N], fhit [N];
  bit active = 1'b0;
  int t = 0;
  logic [N-1:0] exp_bounce = '0;
  bit exp_done = 1'b0;
  bit exp_over = 1'b0;
`ifdef SPRITE_MOTION_COLLISION_EN
  logic [N-1:0] exp_coll = '0;
`endif

  function automatic void axis(input int p, input int s, input int d, input int lim,
                               output int np, output int nd, output int h);
    np = p; nd = d; h = 0;
    if (s != 0) begin
      if (d == 0) begin
        if (p + s >= lim) begin np = lim; nd = 1; h = 1; end
        else np = p + s;
      end else begin
        if (p <= s) begin np = 0; nd = 0; h = 1; end
        else np = p - s;
      end
    end
  endfunction

  always @(posedge clk) begin
    int hx, hy;
    exp_bounce = '0;
    exp_done   = 1'b0;
    exp_over   = 1'b0;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mx[i] = 0; my[i] = 0; mxd[i] = 0; myd[i] = 0; msx[i] = 1; msy[i] = 1;
      end
      active = 1'b0;
      t = 0;
`ifdef SPRITE_MOTION_COLLISION_EN
      exp_coll = '0;
`endif
    end else if (active) begin
      if (next_frame && enable) exp_over = 1'b1;
      t++;
      if (t <= N) begin
        mx[t-1]  = fx[t-1];
        my[t-1]  = fy[t-1];
        mxd[t-1] = fxd[t-1];
        myd[t-1] = fyd[t-1];
        exp_bounce[t-1] = (fhit[t-1] != 0);
      end
      if (t == N) exp_done = 1'b1;
      if (t == N + 1) begin
        active = 1'b0;
`ifdef SPRITE_MOTION_COLLISION_EN
        exp_coll = '0;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            if (i != j && mx[i] < mx[j] + 16 && mx[j] < mx[i] + 16 &&
                my[i] < my[j] + 16 && my[j] < my[i] + 16)
              exp_coll[i] = 1'b1;
`endif
      end
    end else begin
      if (cfg_valid && int'(cfg_idx) < N) begin
        mx[cfg_idx]  = (int'(cfg_x) > XMAX) ? XMAX : int'(cfg_x);
        my[cfg_idx]  = (int'(cfg_y) > YMAX) ? YMAX : int'(cfg_y);
        msx[cfg_idx] = int'(cfg_sx);
        msy[cfg_idx] = int'(cfg_sy);
        mxd[cfg_idx] = int'(cfg_xdir);
        myd[cfg_idx] = int'(cfg_ydir);
      end
      if (next_frame && enable) begin
        active = 1'b1;
        t = 0;
        for (int i = 0; i < N; i++) begin
          axis(mx[i], msx[i], mxd[i], XMAX, fx[i], fxd[i], hx);
          axis(my[i], msy[i], myd[i], YMAX, fy[i], fyd[i], hy);
          fhit[i] = hx | hy;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < N; i++) begin
        chk("x",    sprite_x[i*PW +: PW], mx[i]);
        chk("y",    sprite_y[i*PW +: PW], my[i]);
        chk("xdir", sprite_x_dir[i], mxd[i]);
        chk("ydir", sprite_y_dir[i], myd[i]);
      end
      chk("bounce",        bounce, exp_bounce);
      chk("frame_done",    frame_done, exp_done);
      chk("frame_overrun", frame_overrun, exp_over);
      chk("busy",          busy, active);
      chk("cfg_ready",     cfg_ready, !active);
`ifdef SPRITE_MOTION_COLLISION_EN
      chk("collision",     collision, exp_coll);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic frame();
    next_frame = 1'b1;
    @(negedge clk);
    next_frame = 1'b0;
    repeat (N + 1) @(negedge clk);
  endtask

  task automatic cfg(input int idx, input int x, input int y, input int sx,
                     input int sy, input int xd, input int yd);
    cfg_valid = 1'b1;
    cfg_idx   = 3'(idx);
    cfg_x     = PW'(x);
    cfg_y     = PW'(y);
    cfg_sx    = SW'(sx);
    cfg_sy    = SW'(sy);
    cfg_xdir  = xd[0];
    cfg_ydir  = yd[0];
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    enable = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checking = 1'b1;
    chk("rst_x", sprite_x, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 1);

    // Legacy bounce at the right edge after 144 single-pixel frames.
    repeat (143) frame();
    next_frame = 1'b1;
    @(negedge clk);
    next_frame = 1'b0;
    @(negedge clk);
    chk("f144_bounce0", bounce[0], 1);
    chk("f144_x0", sprite_x[PW-1:0], 144);
    chk("f144_xdir0", sprite_x_dir[0], 1);
    repeat (N) @(negedge clk);
    frame();
    chk("f145_x0", sprite_x[PW-1:0], 143);

    // Overshoot clamps at both edges.
    cfg(1, 142, 0, 5, 0, 0, 0);
    frame();
    chk("over_hi_x1", sprite_x[2*PW-1:PW], 144);
    chk("over_hi_xdir1", sprite_x_dir[1], 1);
    cfg(1, 3, 0, 5, 0, 1, 0);
    frame();
    chk("over_lo_x1", sprite_x[2*PW-1:PW], 0);
    chk("over_lo_xdir1", sprite_x_dir[1], 0);

    // Config refused while sweeping.
    next_frame = 1'b1;
    @(negedge clk);
    next_frame = 1'b0;
    cfg_valid = 1'b1; cfg_idx = 3'd0; cfg_x = 8'd50;
    chk("sweep_cfg_ready", cfg_ready, 0);
    chk("sweep_busy", busy, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (N) @(negedge clk);
    chk("refused_x0", sprite_x[PW-1:0], 140);

    // Back-to-back ticks: one update, one overrun pulse.
    next_frame = 1'b1;
    repeat (2) @(negedge clk);
    next_frame = 1'b0;
    chk("overrun_pulse", frame_overrun, 1);
    repeat (N) @(negedge clk);
    chk("overrun_x0", sprite_x[PW-1:0], 139);

    // Disabled tick is ignored.
    enable = 1'b0;
    next_frame = 1'b1;
    @(negedge clk);
    next_frame = 1'b0;
    @(negedge clk);
    chk("disabled_busy", busy, 0);
    chk("disabled_x0", sprite_x[PW-1:0], 139);
    enable = 1'b1;

    // Reset in the middle of a sweep.
    next_frame = 1'b1;
    @(negedge clk);
    next_frame = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_x0", sprite_x[PW-1:0], 0);
    chk("midrst_busy", busy, 0);

    // Clamped config and an ignored out-of-range index.
    cfg(0, 200, 250, 1, 1, 0, 0);
    chk("clamp_x0", sprite_x[PW-1:0], 144);
    chk("clamp_y0", sprite_y[PW-1:0], 104);
    cfg(5, 7, 7, 1, 1, 0, 0);
    chk("ignored_x0", sprite_x[PW-1:0], 144);

    // Config and tick in the same cycle: the sweep sees the new values.
    cfg_valid = 1'b1; cfg_idx = 3'd1; cfg_x = 8'd10; cfg_y = 8'd20;
    cfg_sx = 3'd2; cfg_sy = 3'd3; cfg_xdir = 1'b0; cfg_ydir = 1'b0;
    next_frame = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    next_frame = 1'b0;
    repeat (N + 1) @(negedge clk);
    chk("same_cycle_x1", sprite_x[2*PW-1:PW], 12);
    chk("same_cycle_y1", sprite_y[2*PW-1:PW], 23);

`ifdef SPRITE_MOTION_COLLISION_EN
    cfg(0, 10, 10, 0, 0, 0, 0);
    cfg(1, 20, 20, 0, 0, 0, 0);
    frame();
    chk("coll_overlap", collision, 3);
    cfg(1, 26, 10, 0, 0, 0, 0);
    frame();
    chk("coll_clear", collision, 0);
`endif

    @(negedge clk);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

`default_nettype wire
